tone_sequencer: RTL and testbench

Command-driven controller for the two-channel square-wave speaker tone generator. Accepts note commands (note index plus duration in ms) over a valid/ready interface and buffers them in a small FIFO. Plays each note by driving the generator's enable and half-period target for the exact commanded duration, with a fixed silent gap between notes. Sits between the host/register interface and the tone generator; the tone generator's counter and toggle logic are unchanged.

---
 rtl/tone_pkg.sv | 14 +
 rtl/tone_cmd_fifo.sv | 43 ++++
 rtl/tone_sequencer.sv | 98 +++++++++
 tb/tb_tone_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: shared types, constants and the note half-period table for the tone sequencer.
package tone_pkg;
  localparam int NUM_NOTES = 17;
  localparam int NOTE_REST_MIN = 17;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  typedef struct packed {
    logic [4:0] note;
    logic [7:0] dur;
  } cmd_t;
  // HALF_PERIOD[n]: 400 Hz rising in 25 Hz steps to 800 Hz at n=16, so strictly decreasing
  function automatic logic [15:0] half_period(int clk_hz, logic [4:0] note);
    return 16'(clk_hz / (800 + 50 * int'(note)));
  endfunction
endpackage

// File: rtl/tone_cmd_fifo.sv
// tone_cmd_fifo: note command FIFO with flush and a registered ready (not-full) flag.
module tone_cmd_fifo
  import tone_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic empty_o,
  output logic ready_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  cmd_t mem_q [DEPTH];
  logic do_push, do_pop;
  assign do_push = push_i && ready_o && !flush_i;
  assign do_pop = pop_i && !empty_o && !flush_i;
  assign cnt_d = flush_i ? '0 : cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign empty_o = cnt_q == '0;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ready_o <= 1'b0;
    end else begin
      wr_q <= flush_i ? '0 : wr_q + AW'(do_push);
      rd_q <= flush_i ? '0 : rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
      ready_o <= cnt_d != (AW+1)'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays queued note commands on the square-wave tone generator,
// holding each note for dur ms and inserting a fixed silent gap between notes.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 32_000_000,
  parameter int TICK_CYCLES = 32000,
  parameter int DEPTH = 4,
  parameter int GAP_MS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_note,
  input  logic [7:0]  cmd_dur_ms,
  input  logic        abort,
  output logic        tone_en,
  output logic [15:0] tone_half_period,
  output logic        busy,
  output logic        note_done
);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_MS - 1);
  localparam logic [4:0] REST = 5'(NOTE_REST_MIN);
  state_t state_q;
  cmd_t cur_q, head;
  logic [TW-1:0] tick_q, tick_nx;
  logic [7:0] ms_q, ms_nx, last_ms;
  logic empty, pop, tick_wrap, at_end, nx_end;
  tone_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(abort),
    .push_i(cmd_valid && !abort),
    .data_i('{note: cmd_note, dur: cmd_dur_ms}),
    .pop_i(pop),
    .data_o(head),
    .empty_o(empty),
    .ready_o(cmd_ready)
  );
  assign tick_wrap = tick_q == TICK_LAST;
  assign tick_nx = tick_wrap ? '0 : tick_q + 1'b1;
  assign ms_nx = ms_q + 8'(tick_wrap);
  assign last_ms = state_q == GAP ? GAP_LAST : cur_q.dur - 8'd1;
  assign at_end = tick_wrap && ms_q == last_ms;
  // note_done is registered, so it is raised one edge early from the next counter values
  assign nx_end = tick_nx == TICK_LAST && ms_nx == last_ms;
  assign busy = state_q != IDLE || !empty;
  assign pop = !abort && !empty && (state_q == IDLE || (state_q == LOAD && cur_q.dur == 8'd0)
             || (at_end && (state_q == GAP || (state_q == PLAY && GAP_MS == 0))));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q <= '0;
      tick_q <= '0;
      ms_q <= '0;
      tone_en <= 1'b0;
      note_done <= 1'b0;
      tone_half_period <= half_period(CLK_HZ, 5'd0);
    end else if (abort) begin
      state_q <= IDLE;
      tone_en <= 1'b0;
      note_done <= 1'b0;
    end else begin
      if (pop) cur_q <= head;
      case (state_q)
        IDLE: state_q <= pop ? LOAD : IDLE;
        LOAD: begin
          if (cur_q.dur == 8'd0) begin
            state_q <= pop ? LOAD : IDLE;
          end else begin
            state_q <= PLAY;
            tick_q <= '0;
            ms_q <= '0;
            tone_en <= cur_q.note < REST;
            if (cur_q.note < REST) tone_half_period <= half_period(CLK_HZ, cur_q.note);
            note_done <= TICK_CYCLES == 1 && cur_q.dur == 8'd1;
          end
        end
        default: begin
          if (at_end) begin
            state_q <= state_q == PLAY && GAP_MS > 0 ? GAP : pop ? LOAD : IDLE;
            tick_q <= '0;
            ms_q <= '0;
            tone_en <= 1'b0;
            note_done <= 1'b0;
          end else begin
            tick_q <= tick_nx;
            ms_q <= ms_nx;
            note_done <= state_q == PLAY && nx_end;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and random note commands checked each cycle against a
// queue-and-countdown model of the sequencer built from its behavioural rules.
module tb_tone_sequencer;
  localparam int T = 4;
  localparam int G = 1;
  localparam int D = 4;
  localparam int K_IDLE = 0, K_LOAD = 1, K_PLAY = 2, K_GAP = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  logic [4:0] cmd_note = '0;
  logic [7:0] cmd_dur_ms = '0;
  logic cmd_ready, tone_en, busy, note_done;
  logic [15:0] tone_half_period;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  typedef struct {
    int note;
    int dur;
  } mcmd_t;
  mcmd_t q[$];
  mcmd_t cur;
  int kind, rem, m_half;
  bit m_en, m_nd, m_rdy;

  always #5 clk = ~clk;

  tone_sequencer #(.CLK_HZ(32_000_000), .TICK_CYCLES(T), .DEPTH(D), .GAP_MS(G)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_note(cmd_note),
    .cmd_dur_ms(cmd_dur_ms),
    .abort(abort),
    .tone_en(tone_en),
    .tone_half_period(tone_half_period),
    .busy(busy),
    .note_done(note_done)
  );

  function automatic int hp(int n);
    return 32_000_000 / (2 * (400 + 25 * n));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    kind = K_IDLE;
    rem = 0;
    m_en = 0;
    m_nd = 0;
    m_rdy = 0;
    m_half = hp(0);
  endtask

  task automatic take_next();
    if (q.size() > 0) begin
      cur = q.pop_front();
      kind = K_LOAD;
    end else kind = K_IDLE;
  endtask

  task automatic model_edge(bit v, int n, int d, bit ab);
    bit push;
    push = v && m_rdy;
    if (ab) begin
      q.delete();
      kind = K_IDLE;
      m_en = 0;
      m_nd = 0;
    end else begin
      case (kind)
        K_IDLE: take_next();
        K_LOAD: begin
          if (cur.dur == 0) take_next();
          else begin
            kind = K_PLAY;
            rem = cur.dur * T;
            m_en = cur.note < 17;
            if (cur.note < 17) m_half = hp(cur.note);
          end
        end
        K_PLAY: begin
          rem--;
          if (rem == 0) begin
            m_en = 0;
            if (G > 0) begin
              kind = K_GAP;
              rem = G * T;
            end else take_next();
          end
        end
        default: begin
          rem--;
          if (rem == 0) take_next();
        end
      endcase
      m_nd = kind == K_PLAY && rem == 1;
      if (push) q.push_back('{n, d});
    end
    m_rdy = q.size() != D;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(cmd_valid, int'(cmd_note), int'(cmd_dur_ms), abort);
    #1;
    chk("tone_en", tone_en, m_en);
    chk("tone_half_period", tone_half_period, m_half);
    chk("note_done", note_done, m_nd);
    chk("busy", busy, kind != K_IDLE || q.size() > 0);
    chk("cmd_ready", cmd_ready, m_rdy);
    dones += int'(note_done);
  endtask

  task automatic run(int k);
    repeat (k) step();
  endtask

  task automatic send(int n, int d);
    cmd_valid = 1'b1;
    cmd_note = 5'(n);
    cmd_dur_ms = 8'(d);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int i;
    i = 0;
    while (i < max && (busy || kind != K_IDLE || q.size() > 0)) begin
      step();
      i++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tone_en", tone_en, 0);
    chk("rst_half", tone_half_period, 40000);
    chk("rst_busy", busy, 0);
    chk("rst_note_done", note_done, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", cmd_ready, 1);

    dones = 0;
    send(0, 3);
    wait_idle(40);
    chk("s1_note_done_count", dones, 1);
    chk("s1_half", tone_half_period, 40000);

    dones = 0;
    send(16, 1);
    send(20, 2);
    send(16, 1);
    wait_idle(80);
    chk("s2_note_done_count", dones, 3);
    chk("s2_half", tone_half_period, 20000);

    dones = 0;
    cmd_valid = 1'b1;
    cmd_dur_ms = 8'd1;
    for (int i = 0; i < 6; i++) begin
      cmd_note = 5'(2 + i);
      step();
    end
    cmd_valid = 1'b0;
    chk("s3_ready_dropped", cmd_ready, 0);
    wait_idle(200);
    chk("s3_note_done_count", dones, D + 1);

    dones = 0;
    send(5, 0);
    send(3, 1);
    wait_idle(40);
    chk("s4_note_done_count", dones, 1);
    chk("s4_half", tone_half_period, hp(3));

    send(2, 3);
    send(4, 1);
    send(6, 1);
    run(3);
    chk("s5_playing", tone_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s5_abort_tone_en", tone_en, 0);
    chk("s5_abort_busy", busy, 0);
    dones = 0;
    run(30);
    chk("s5_no_more_notes", dones, 0);

    send(7, 1);
    run(7);
    chk("s6_in_gap_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6_rst_tone_en", tone_en, 0);
    chk("s6_rst_half", tone_half_period, 40000);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_note_done", note_done, 0);
    chk("s6_rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("s6_ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_note = 5'($urandom_range(0, 31));
      cmd_dur_ms = 8'($urandom_range(0, 3));
      abort = $urandom_range(0, 39) == 0;
      step();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    wait_idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
